// File: rtl/protocol_request_parser.sv
// Receive-side decoder for adapter protocol frames: magic check, command lookup,
// argument capture, and exactly one request or classified error per frame.
package protocol_pkg;
   localparam logic [31:0] PROTOCOL_MAGIC = 32'hDEADBEEF;
   localparam logic [7:0]  CMD_IDENTIFY   = 8'h01;
   localparam logic [7:0]  CMD_SET_SIGNAL = 8'h02;
   localparam logic [7:0]  CMD_AUTO_READ  = 8'h03;
   localparam logic [7:0]  CMD_GET_RESULT = 8'h04;
   localparam logic [7:0]  CMD_ABORT      = 8'h05;
endpackage

module protocol_request_parser #(
   parameter logic [31:0] MAGIC    = protocol_pkg::PROTOCOL_MAGIC,
   parameter int          NUM_CMDS = 5,
   parameter int          MAX_ARGS = 10,
   parameter logic [7:0]  CMD_CODES [NUM_CMDS] = '{protocol_pkg::CMD_IDENTIFY,
                                                   protocol_pkg::CMD_SET_SIGNAL,
                                                   protocol_pkg::CMD_AUTO_READ,
                                                   protocol_pkg::CMD_GET_RESULT,
                                                   protocol_pkg::CMD_ABORT},
   parameter logic [7:0]  CMD_LENS  [NUM_CMDS] = '{8'd0, 8'd4, 8'd10, 8'd0, 8'd0}
) (
   input  logic                            clk_i,
   input  logic                            rst_i,
   input  logic                            flush_i,
   input  logic                            in_valid_i,
   input  logic [7:0]                      in_data_i,
   input  logic                            in_last_i,
   input  logic                            in_error_i,
   output logic                            req_valid_o,
   output logic [7:0]                      req_cmd_o,
   output logic [$clog2(NUM_CMDS)-1:0]     req_cmd_idx_o,
   output logic [8*MAX_ARGS-1:0]           req_args_o,
   output logic [$clog2(MAX_ARGS+1)-1:0]   req_args_len_o,
   output logic                            err_valid_o,
   output logic [2:0]                      err_code_o,
   output logic                            busy_o
);
   localparam int IW = $clog2(NUM_CMDS);
   localparam int LW = $clog2(MAX_ARGS+1);
   localparam int AW = $clog2(MAX_ARGS+2);

   localparam logic [2:0] ERR_NONE   = 3'd0;
   localparam logic [2:0] ERR_LINK   = 3'd1;
   localparam logic [2:0] ERR_MAGIC  = 3'd2;
   localparam logic [2:0] ERR_CMD    = 3'd3;
   localparam logic [2:0] ERR_LENGTH = 3'd4;

   typedef enum logic [2:0] {S_IDLE, S_MAGIC, S_CMD, S_ARGS, S_DISCARD} state_t;

   state_t                state_q, state_d;
   logic [1:0]            pos_q, pos_d, mpos;
   logic [AW-1:0]         argcnt_q, argcnt_d, cnt_inc;
   logic [IW-1:0]         idx_q, idx_d, hit_idx, sel_idx;
   logic [7:0]            cmd_q, cmd_d, exp_len;
   logic [2:0]            pend_q, pend_d, end_code, err_d;
   logic [8*MAX_ARGS-1:0] shadow_q, shadow_d;
   logic [NUM_CMDS-1:0]   hit;
   logic                  req_fire, err_fire;

   for (genvar gi = 0; gi < NUM_CMDS; gi++) begin : g_hit
      assign hit[gi] = (in_data_i == CMD_CODES[gi]);
   end

   assign mpos    = (state_q == S_IDLE) ? 2'd0 : pos_q;
   assign sel_idx = (state_q == S_CMD) ? hit_idx : idx_q;
   // argcnt parks at MAX_ARGS+1 so any overlength frame stays distinguishable
   assign cnt_inc = (argcnt_q == AW'(MAX_ARGS+1)) ? argcnt_q : argcnt_q + AW'(1);
   assign busy_o  = (state_q != S_IDLE);

   always_comb begin
      hit_idx = '0;
      for (int i = NUM_CMDS-1; i >= 0; i--)
         if (hit[i]) hit_idx = IW'(i);
      exp_len = '0;
      for (int i = 0; i < NUM_CMDS; i++)
         if (sel_idx == IW'(i)) exp_len = CMD_LENS[i];
   end

   always_comb begin
      state_d  = state_q;
      pos_d    = pos_q;
      argcnt_d = argcnt_q;
      idx_d    = idx_q;
      cmd_d    = cmd_q;
      pend_d   = pend_q;
      shadow_d = shadow_q;
      end_code = ERR_NONE;
      err_d    = ERR_NONE;
      req_fire = 1'b0;
      err_fire = 1'b0;
      if (flush_i) begin
         state_d  = S_IDLE;
         pos_d    = 2'd0;
         argcnt_d = '0;
         pend_d   = ERR_NONE;
         shadow_d = '0;
      end else if (in_valid_i) begin
         case (state_q)
            S_IDLE, S_MAGIC: begin
               if (state_q == S_IDLE) begin
                  shadow_d = '0;
                  argcnt_d = '0;
                  pend_d   = ERR_NONE;
               end
               if (in_data_i != MAGIC[8*mpos +: 8]) begin
                  pend_d   = ERR_MAGIC;
                  state_d  = S_DISCARD;
                  end_code = ERR_MAGIC;
               end else if (mpos == 2'd3) begin
                  state_d  = S_CMD;
                  end_code = ERR_CMD;
               end else begin
                  state_d  = S_MAGIC;
                  pos_d    = mpos + 2'd1;
                  end_code = ERR_MAGIC;
               end
            end
            S_CMD: begin
               if (|hit) begin
                  idx_d    = hit_idx;
                  cmd_d    = in_data_i;
                  argcnt_d = '0;
                  state_d  = S_ARGS;
                  end_code = (exp_len == 8'd0) ? ERR_NONE : ERR_LENGTH;
               end else begin
                  pend_d   = ERR_CMD;
                  state_d  = S_DISCARD;
                  end_code = ERR_CMD;
               end
            end
            S_ARGS: begin
               for (int i = 0; i < MAX_ARGS; i++)
                  if (argcnt_q == AW'(i)) shadow_d[8*i +: 8] = in_data_i;
               argcnt_d = cnt_inc;
               end_code = (8'(cnt_inc) == exp_len) ? ERR_NONE : ERR_LENGTH;
            end
            default: end_code = pend_q;
         endcase
         if (in_last_i) begin
            state_d = S_IDLE;
            if (in_error_i) begin
               err_fire = 1'b1;
               err_d    = ERR_LINK;
            end else if (end_code != ERR_NONE) begin
               err_fire = 1'b1;
               err_d    = end_code;
            end else begin
               req_fire = 1'b1;
            end
         end
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q  <= S_IDLE;
         pos_q    <= 2'd0;
         argcnt_q <= '0;
         idx_q    <= '0;
         cmd_q    <= '0;
         pend_q   <= ERR_NONE;
         shadow_q <= '0;
      end else begin
         state_q  <= state_d;
         pos_q    <= pos_d;
         argcnt_q <= argcnt_d;
         idx_q    <= idx_d;
         cmd_q    <= cmd_d;
         pend_q   <= pend_d;
         shadow_q <= shadow_d;
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         req_valid_o    <= 1'b0;
         req_cmd_o      <= '0;
         req_cmd_idx_o  <= '0;
         req_args_o     <= '0;
         req_args_len_o <= '0;
         err_valid_o    <= 1'b0;
         err_code_o     <= ERR_NONE;
      end else begin
         req_valid_o <= req_fire;
         err_valid_o <= err_fire;
         if (req_fire) begin
            req_cmd_o      <= cmd_d;
            req_cmd_idx_o  <= idx_d;
            req_args_o     <= shadow_d;
            req_args_len_o <= LW'(exp_len);
         end
         if (err_fire) err_code_o <= err_d;
      end
   end
endmodule

// File: tb/tb_protocol_request_parser.sv
// Bench for protocol_request_parser: directed vector table, hand-written flush and
// reset sequences, and random frames scored against a whole-frame reference model.
module tb_protocol_request_parser;
   localparam logic [31:0] M    = 32'hDEADBEEF;
   localparam logic [7:0]  C_ID = 8'h01;
   localparam logic [7:0]  C_SS = 8'h02;
   localparam logic [7:0]  C_AR = 8'h03;
   localparam logic [7:0]  C_GR = 8'h04;
   localparam logic [7:0]  C_AB = 8'h05;
   localparam int          NV   = 15;

   logic        clk = 1'b0;
   logic        rst, flush, in_valid, in_last, in_error;
   logic [7:0]  in_data;
   logic        req_valid, err_valid, busy;
   logic [7:0]  req_cmd;
   logic [2:0]  req_cmd_idx, err_code;
   logic [79:0] req_args;
   logic [3:0]  req_args_len;

   protocol_request_parser dut (
      .clk_i(clk), .rst_i(rst), .flush_i(flush), .in_valid_i(in_valid),
      .in_data_i(in_data), .in_last_i(in_last), .in_error_i(in_error),
      .req_valid_o(req_valid), .req_cmd_o(req_cmd), .req_cmd_idx_o(req_cmd_idx),
      .req_args_o(req_args), .req_args_len_o(req_args_len),
      .err_valid_o(err_valid), .err_code_o(err_code), .busy_o(busy)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic        req;
      logic [2:0]  code;
      logic [7:0]  cmd;
      logic [2:0]  idx;
      logic [3:0]  len;
      logic [79:0] args;
      int          cyc;
   } exp_t;

   typedef struct packed {
      int           n;
      logic [191:0] d;
      logic         err;
      exp_t         e;
   } vec_t;

   logic [7:0] codes [5] = '{C_ID, C_SS, C_AR, C_GR, C_AB};
   int         lens  [5] = '{0, 4, 10, 0, 0};

   vec_t  tab [NV];
   exp_t  exp_q [$];
   int    checks = 0;
   int    errors = 0;
   int    cyc = 0;
   logic [7:0]  last_cmd = '0;
   logic [2:0]  last_idx = '0, last_code = '0;
   logic [3:0]  last_len = '0;
   logic [79:0] last_args = '0;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [79:0] act, input logic [79:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Whole-frame reference: decide the outcome from the complete byte list.
   function automatic exp_t model(input logic [191:0] d, input int n, input logic err);
      exp_t e;
      int   ci;
      e  = '0;
      ci = -1;
      if (err) e.code = 3'd1;
      else if (n < 4 || d[31:0] != M) e.code = 3'd2;
      else if (n < 5) e.code = 3'd3;
      else begin
         for (int i = 0; i < 5; i++)
            if (ci < 0 && codes[i] == d[39:32]) ci = i;
         if (ci < 0) e.code = 3'd3;
         else if (n - 5 != lens[ci]) e.code = 3'd4;
         else begin
            e.req = 1'b1;
            e.cmd = d[39:32];
            e.idx = 3'(ci);
            e.len = 4'(lens[ci]);
            for (int i = 0; i < n - 5; i++) e.args[8*i +: 8] = d[40 + 8*i +: 8];
         end
      end
      return e;
   endfunction

   function automatic vec_t mkv(input int n, input logic [191:0] d, input logic err,
                                input logic req, input logic [2:0] code, input logic [2:0] idx,
                                input logic [3:0] len, input logic [79:0] args);
      vec_t v;
      v = '0;
      v.n = n; v.d = d; v.err = err;
      v.e.req = req; v.e.code = code; v.e.idx = idx; v.e.len = len; v.e.args = args;
      v.e.cmd = req ? d[39:32] : 8'h00;
      return v;
   endfunction

   task automatic send_frame(input logic [191:0] d, input int n, input logic err,
                             input exp_t e, input logic term);
      for (int i = 0; i < n; i++) begin
         @(negedge clk);
         in_valid = 1'b1;
         in_data  = d[8*i +: 8];
         in_last  = term && (i == n - 1);
         in_error = err && term && (i == n - 1);
         if (term && i == n - 1) begin
            e.cyc = cyc + 1;
            exp_q.push_back(e);
         end
      end
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) begin
         @(negedge clk);
         in_valid = 1'b0; in_last = 1'b0; in_error = 1'b0; in_data = 8'h00;
      end
   endtask

   // Pulse scoreboard: every pulse must match the oldest expectation at its exact cycle.
   always @(negedge clk) begin
      exp_t e;
      if (req_valid && err_valid) chk("both_pulses", 80'd1, 80'd0);
      if (req_valid || err_valid) begin
         if (exp_q.size() == 0) chk("unexpected_pulse", 80'(req_valid), 80'(1'b0) + 80'(err_valid) - 80'(err_valid));
         else begin
            e = exp_q.pop_front();
            chk("latency", 80'(cyc), 80'(e.cyc));
            chk("pulse_kind", 80'(req_valid), 80'(e.req));
            if (e.req) begin
               chk("req_cmd", 80'(req_cmd), 80'(e.cmd));
               chk("req_cmd_idx", 80'(req_cmd_idx), 80'(e.idx));
               chk("req_args", req_args, e.args);
               chk("req_args_len", 80'(req_args_len), 80'(e.len));
               chk("err_code_hold", 80'(err_code), 80'(last_code));
               last_cmd = e.cmd; last_idx = e.idx; last_args = e.args; last_len = e.len;
            end else begin
               chk("err_code", 80'(err_code), 80'(e.code));
               chk("req_args_hold", req_args, last_args);
               chk("req_cmd_hold", 80'(req_cmd), 80'(last_cmd));
               last_code = e.code;
            end
         end
      end else if (exp_q.size() != 0 && cyc > exp_q[0].cyc) begin
         e = exp_q.pop_front();
         chk("missing_pulse", 80'd0, 80'd1);
      end
   end

   task automatic check_all_zero(input string tag);
      chk({tag, "_req_valid"}, 80'(req_valid), 80'd0);
      chk({tag, "_err_valid"}, 80'(err_valid), 80'd0);
      chk({tag, "_req_cmd"}, 80'(req_cmd), 80'd0);
      chk({tag, "_req_idx"}, 80'(req_cmd_idx), 80'd0);
      chk({tag, "_req_args"}, req_args, 80'd0);
      chk({tag, "_req_len"}, 80'(req_args_len), 80'd0);
      chk({tag, "_err_code"}, 80'(err_code), 80'd0);
      chk({tag, "_busy"}, 80'(busy), 80'd0);
   endtask

   initial begin
      logic [191:0] rd;
      logic [7:0]   flip;
      logic         rerr;
      int           rn, rci, rna, r, bi, g;
      exp_t         e;

      rst = 1'b1; flush = 1'b0; in_valid = 1'b0; in_last = 1'b0; in_error = 1'b0; in_data = 8'h00;

      tab[0]  = mkv(15, 192'({80'h0A090807060504030201, C_AR, M}), 1'b0, 1'b1, 3'd0, 3'd2, 4'd10, 80'h0A090807060504030201);
      tab[1]  = mkv(9,  192'({32'h01FF1234, C_SS, M}), 1'b0, 1'b1, 3'd0, 3'd1, 4'd4, 80'h01FF1234);
      tab[2]  = mkv(5,  192'({C_ID, M}), 1'b0, 1'b1, 3'd0, 3'd0, 4'd0, 80'h0);
      tab[3]  = mkv(5,  192'({C_ID, 32'h00ADBEEF}), 1'b0, 1'b0, 3'd2, 3'd0, 4'd0, 80'h0);
      tab[4]  = mkv(5,  192'({C_ID, 32'h00ADBEEF}), 1'b1, 1'b0, 3'd1, 3'd0, 4'd0, 80'h0);
      tab[5]  = mkv(3,  192'(M), 1'b0, 1'b0, 3'd2, 3'd0, 4'd0, 80'h0);
      tab[6]  = mkv(5,  192'({8'h77, M}), 1'b0, 1'b0, 3'd3, 3'd0, 4'd0, 80'h0);
      tab[7]  = mkv(4,  192'(M), 1'b0, 1'b0, 3'd3, 3'd0, 4'd0, 80'h0);
      tab[8]  = mkv(8,  192'({24'hFF1234, C_SS, M}), 1'b0, 1'b0, 3'd4, 3'd0, 4'd0, 80'h0);
      tab[9]  = mkv(10, 192'({40'h5501FF1234, C_SS, M}), 1'b0, 1'b0, 3'd4, 3'd0, 4'd0, 80'h0);
      tab[10] = mkv(19, 192'({112'h0E0D0C0B0A090807060504030201, C_AR, M}), 1'b0, 1'b0, 3'd4, 3'd0, 4'd0, 80'h0);
      tab[11] = mkv(1,  192'(M), 1'b0, 1'b0, 3'd2, 3'd0, 4'd0, 80'h0);
      tab[12] = mkv(1,  192'(M), 1'b1, 1'b0, 3'd1, 3'd0, 4'd0, 80'h0);
      tab[13] = mkv(5,  192'({C_GR, M}), 1'b0, 1'b1, 3'd0, 3'd3, 4'd0, 80'h0);
      tab[14] = mkv(5,  192'({C_AB, M}), 1'b0, 1'b1, 3'd0, 3'd4, 4'd0, 80'h0);

      repeat (2) @(negedge clk);
      check_all_zero("reset");
      rst = 1'b0;

      // Directed table, frames back-to-back with no idle cycle between them
      for (int i = 0; i < NV; i++) begin
         send_frame(tab[i].d, tab[i].n, tab[i].err, tab[i].e, 1'b1);
         $display("vector %0d: %0d bytes err=%0b -> req=%0b code=%0d", i, tab[i].n, tab[i].err, tab[i].e.req, tab[i].e.code);
      end
      idle(3);

      // flush after byte 2 with a byte on the same cycle: frame dropped silently
      e = '0;
      send_frame(192'(M), 3, 1'b0, e, 1'b0);
      @(negedge clk);
      chk("busy_mid_frame", 80'(busy), 80'd1);
      flush = 1'b1; in_valid = 1'b1; in_data = 8'hDE; in_last = 1'b0;
      @(negedge clk);
      flush = 1'b0; in_valid = 1'b0;
      chk("busy_after_flush", 80'(busy), 80'd0);
      send_frame(192'({C_ID, M}), 5, 1'b0, model(192'({C_ID, M}), 5, 1'b0), 1'b1);
      idle(3);
      $display("flush sequence done");

      // async reset while in ARGS, then a full frame must still decode
      send_frame(192'({32'h01FF1234, C_SS, M}), 9, 1'b0, model(192'({32'h01FF1234, C_SS, M}), 9, 1'b0), 1'b1);
      idle(2);
      send_frame(192'({24'h030201, C_AR, M}), 8, 1'b0, e, 1'b0);
      @(negedge clk);
      in_valid = 1'b0; in_last = 1'b0;
      rst = 1'b1;
      #1;
      check_all_zero("mid_args_rst");
      last_cmd = '0; last_idx = '0; last_code = '0; last_len = '0; last_args = '0;
      @(negedge clk);
      rst = 1'b0;
      rd = 192'({80'h0A090807060504030201, C_AR, M});
      send_frame(rd, 15, 1'b0, model(rd, 15, 1'b0), 1'b1);
      idle(3);
      $display("reset sequence done");

      // Random frames against the reference model
      for (int k = 0; k < 200; k++) begin
         rd = '0;
         r   = $urandom_range(0, 9);
         rci = $urandom_range(0, 4);
         rna = lens[rci];
         rd[31:0]  = M;
         rd[39:32] = codes[rci];
         if (r <= 1) begin
            bi   = $urandom_range(0, 3);
            flip = 8'h01 << $urandom_range(0, 7);
            rd[8*bi +: 8] = rd[8*bi +: 8] ^ flip;
         end
         if (r == 2) rd[39:32] = 8'($urandom);
         if (r == 3) rna = $urandom_range(0, 14);
         for (int i = 0; i < rna; i++) rd[40 + 8*i +: 8] = 8'($urandom);
         rn = 5 + rna;
         if (r == 4) rn = $urandom_range(1, 4);
         rerr = ($urandom_range(0, 9) == 0);
         e = model(rd, rn, rerr);
         send_frame(rd, rn, rerr, e, 1'b1);
         $display("random %0d: %0d bytes cmd=%0h err=%0b -> req=%0b code=%0d", k, rn, rd[39:32], rerr, e.req, e.code);
         g = $urandom_range(0, 2);
         if (g > 0) idle(g);
      end
      idle(4);
      chk("pending_expectations", 80'(exp_q.size()), 80'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
